// File: rtl/rr_delay_line_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dla_pkg
// Shared helpers and reset constants for rr_delay_line_arbiter.
//   calc_idw(n)      : requester-ID width, max(1, clog2(n))
//   PTR_RST          : round-robin pointer value after reset
//   STAGE_*_RST      : field values of every delay stage after reset
// The stage record itself is a packed struct declared inside the top module,
// because its field widths follow that module's NREQ/WIDTH parameters.
// ---------------------------------------------------------------------------
package dla_pkg;

    function automatic int calc_idw(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    localparam int   PTR_RST         = 0;
    localparam logic STAGE_VALID_RST = 1'b0;
    localparam int   STAGE_ID_RST    = 0;
    localparam int   STAGE_DATA_RST  = 0;

endpackage

// File: rtl/rr_delay_line_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Pure combinational round-robin picker. Scans i_req starting at i_ptr,
// wrapping at NREQ-1 -> 0, and grants the first set bit.
// Ports:
//   i_req   [NREQ]  request vector
//   i_ptr   [IDW]   search start index (always < NREQ)
//   o_grant [NREQ]  one-hot grant, all zero when no request
//   o_idx   [IDW]   index of the granted requester (0 when none)
//   o_any           at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import dla_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    // Index of the k-th candidate in search order, kept below NREQ.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    logic [IDW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = wrap_idx(i_ptr, k);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_delay_line_arbiter.sv
// ---------------------------------------------------------------------------
// rr_delay_line_arbiter
// Shares one DEPTH-stage registered delay line among NREQ requesters. A
// round-robin arbiter admits at most one word per cycle; the word is tagged
// with its requester ID and advances one stage per clock with no backpressure.
//
// Handshake: requester i transfers at a rising edge when req_valid[i] and
// req_ready[i] are both 1. req_ready is combinational, one-hot, depends only
// on req_valid and the pointer (never on req_data), and is forced to 0 during
// reset or flush. A requester may hold req_valid across cycles; it is simply
// re-arbitrated each cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid [NREQ]      per-requester word available
//   req_data  [NREQ*W]    packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready [NREQ]      one-hot grant
//   flush                 synchronous clear of all stage valid bits
//   out_valid/data/id     contents of the last stage (DEPTH-1)
//   occupancy             (only with RR_DLA_OCCUPANCY_EN) count of valid stages
//
// Optional feature macro: RR_DLA_OCCUPANCY_EN adds the occupancy counter/port.
// ---------------------------------------------------------------------------
module rr_delay_line_arbiter
    import dla_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int IDW   = calc_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id
`ifdef RR_DLA_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    typedef struct packed {
        logic             valid;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } stage_t;

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    stage_t           r_stage [DEPTH];
    logic [IDW-1:0]   r_ptr;

    logic [NREQ-1:0]  w_req_eff;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_words [NREQ];

    // Reset and flush both suppress arbitration, so no transfer can be
    // recorded in the same cycle the line is being cleared.
    assign w_req_eff = (rst_n && !flush) ? req_valid : '0;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_words[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_xfer)
    );

    assign req_ready = w_grant;

    // Round-robin pointer: moves just past the winner, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(PTR_RST);
        end else if (w_xfer) begin
            r_ptr <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

    // Delay line. Flush only drops valid bits; stale data/id are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_stage[j] <= '{valid: STAGE_VALID_RST,
                                id:    IDW'(STAGE_ID_RST),
                                data:  WIDTH'(STAGE_DATA_RST)};
            end
        end else if (flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_stage[j].valid <= 1'b0;
            end
        end else begin
            r_stage[0].valid <= w_xfer;
            if (w_xfer) begin
                r_stage[0].id   <= w_idx;
                r_stage[0].data <= w_words[w_idx];
            end
            for (int j = 1; j < DEPTH; j++) begin
                r_stage[j] <= r_stage[j-1];
            end
        end
    end

    assign out_valid = r_stage[DEPTH-1].valid;
    assign out_data  = r_stage[DEPTH-1].data;
    assign out_id    = r_stage[DEPTH-1].id;

`ifdef RR_DLA_OCCUPANCY_EN
    localparam int OCCW = $clog2(DEPTH + 1);

    logic [OCCW-1:0] r_occ;

    // One word enters per transfer and one leaves whenever the last stage is
    // valid, so the count tracks the number of valid stages exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCCW'(w_xfer) - OCCW'(r_stage[DEPTH-1].valid);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_rr_delay_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_delay_line_arbiter
// Self-checking bench for rr_delay_line_arbiter (NREQ=4, WIDTH=8). DEPTH is
// 2 by default and 4 when RR_DLA_OCCUPANCY_EN is defined.
// A reference model tracks the round-robin pointer and the valid bits of the
// delay line; accepted words are pushed to exp_q and popped when the model
// says they reach the output.
// ---------------------------------------------------------------------------
module tb_rr_delay_line_arbiter;

`ifdef RR_DLA_OCCUPANCY_EN
    localparam int TB_DEPTH = 4;
`else
    localparam int TB_DEPTH = 2;
`endif
    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int IDW    = 2;
    localparam int NO_DIR = -2;

    // ---------------- clock / reset ----------------
    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  flush = 1'b0;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
`ifdef RR_DLA_OCCUPANCY_EN
    logic [$clog2(TB_DEPTH+1)-1:0] occupancy;
`endif

    always #5 clk = ~clk;

    rr_delay_line_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .DEPTH (TB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef RR_DLA_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    // ---------------- scoreboard / model ----------------
    logic [IDW+WIDTH-1:0] exp_q[$];
    int                   m_ptr;
    logic                 m_v [TB_DEPTH];
    int                   n_checks = 0;
    int                   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input logic f);
        int idx;
        if (!rst_n || f) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        for (int j = 0; j < TB_DEPTH; j++) c += int'(m_v[j]);
        return c;
    endfunction

    task automatic model_clear();
        m_ptr = 0;
        for (int j = 0; j < TB_DEPTH; j++) m_v[j] = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic [IDW+WIDTH-1:0] e;
        check_eq("out_valid", out_valid, m_v[TB_DEPTH-1]);
        if (m_v[TB_DEPTH-1]) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_id", out_id, e[IDW+WIDTH-1:WIDTH]);
                check_eq("out_data", out_data, e[WIDTH-1:0]);
            end
        end
`ifdef RR_DLA_OCCUPANCY_EN
        check_eq("occupancy", occupancy, model_count());
        check_eq("occ_bound", (occupancy <= TB_DEPTH), 1);
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1; checks mid-cycle, away from the edge.
    task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d,
                               input logic f, input int exp_gnt);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        flush     = f;
        #4;
        g       = model_grant(v, f);
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        check_eq("req_ready", req_ready, exp_rdy);
        if (exp_gnt != NO_DIR)
            check_eq("dir_grant", req_ready, (exp_gnt < 0) ? 0 : (1 << exp_gnt));
        check_outputs();
        if (f) begin
            for (int j = 0; j < TB_DEPTH; j++) m_v[j] = 1'b0;
            exp_q.delete();
        end else begin
            for (int j = TB_DEPTH - 1; j > 0; j--) m_v[j] = m_v[j-1];
            m_v[0] = (g >= 0);
            if (g >= 0) begin
                exp_q.push_back({IDW'(g), d[g*WIDTH +: WIDTH]});
                m_ptr = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0, '0, 1'b0, NO_DIR);
    endtask

    // Asserts reset mid-cycle with all requesters valid.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '1;
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_id", out_id, 0);
`ifdef RR_DLA_OCCUPANCY_EN
        check_eq("rst_occ", occupancy, 0);
`endif
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_ready", req_ready, 0);
            check_eq("rst_hold_valid", out_valid, 0);
        end
        req_valid = '0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ*WIDTH-1:0] rand_data();
        return {8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255))};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-flight: word from req1 discarded, pointer back to 0.
        drive_cycle(4'b0010, 32'h0000_A500, 1'b0, 1);
        do_reset();
        drive_cycle(4'b1111, rand_data(), 1'b0, 0);
        idle(TB_DEPTH + 1);

        // Round-robin over all four requesters from ptr=0.
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(4'b1111, rand_data(), 1'b0, i % NREQ);
        idle(TB_DEPTH + 1);

        // Wrap and skip: ptr -> 3, then 0101 grants 0, 2, 0.
        drive_cycle(4'b0100, rand_data(), 1'b0, 2);
        drive_cycle(4'b0101, rand_data(), 1'b0, 0);
        drive_cycle(4'b0101, rand_data(), 1'b0, 2);
        drive_cycle(4'b0101, rand_data(), 1'b0, 0);
        idle(TB_DEPTH + 1);

        // Latency and data of a single word.
        drive_cycle(4'b0100, 32'h003C_0000, 1'b0, 2);
        idle(TB_DEPTH + 2);

        // Flush with words in flight; req0 granted once flush drops.
        drive_cycle(4'b1111, rand_data(), 1'b0, NO_DIR);
        drive_cycle(4'b1111, rand_data(), 1'b0, NO_DIR);
        drive_cycle(4'b0001, rand_data(), 1'b1, -1);
        idle(2);
        drive_cycle(4'b0001, rand_data(), 1'b0, 0);
        drive_cycle(4'b1111, rand_data(), 1'b0, 1);
        idle(TB_DEPTH + 1);

        // Occupancy ramp, drain, and flush-to-zero (model counts stages).
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(4'b1111, rand_data(), 1'b0, NO_DIR);
        idle(TB_DEPTH + 1);
        drive_cycle(4'b1111, rand_data(), 1'b0, NO_DIR);
        drive_cycle(4'b1111, rand_data(), 1'b0, NO_DIR);
        drive_cycle(4'b0000, rand_data(), 1'b1, -1);
        idle(2);

        // Random traffic with occasional flush.
        for (int i = 0; i < 80; i++) begin
            drive_cycle(NREQ'($urandom_range(15)), rand_data(),
                        ($urandom_range(9) == 0), NO_DIR);
        end
        idle(TB_DEPTH + 1);
        check_eq("sb_drained", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
